// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and constants for the serial-to-word collector.
//   sipo_state_e       - collector FSM states
//   SIPO_WIDTH_DEFAULT - default data word width
//   SIPO_QDEPTH        - output queue depth
package sipo_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PARITY  = 1'b1
    } sipo_state_e;

    localparam int SIPO_WIDTH_DEFAULT = 4;
    localparam int SIPO_QDEPTH        = 2;

endpackage

// File: rtl/sipo_out_queue.sv
// sipo_out_queue: 2-entry registered FIFO with valid/ready style pop.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   push        - write push_data this cycle
//   push_data   - word to enqueue
//   pop         - remove head this cycle (ignored when empty)
//   dout        - head-of-queue word (registered; holds last value when empty)
//   dout_valid  - queue non-empty
//   full        - both entries occupied
//   drop        - push rejected: full with no pop in the same cycle
module sipo_out_queue
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             drop
);

    localparam int CNT_W = $clog2(SIPO_QDEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SIPO_QDEPTH);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        drop   = 1'b0;
        do_pop = pop && (cnt_q != '0);
        case (cnt_q)
            CNT_W'(0): begin
                if (push) begin
                    head_d = push_data;
                    cnt_d  = CNT_W'(1);
                end
            end
            CNT_W'(1): begin
                if (push && do_pop) begin
                    head_d = push_data;
                end else if (do_pop) begin
                    // head keeps the popped word so dout holds it while empty
                    cnt_d = CNT_W'(0);
                end else if (push) begin
                    tail_d = push_data;
                    cnt_d  = CNT_W'(2);
                end
            end
            default: begin
                if (do_pop) begin
                    head_d = tail_q;
                    if (push) tail_d = push_data;
                    else      cnt_d  = CNT_W'(1);
                end else if (push) begin
                    drop = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout       = head_q;
    assign dout_valid = (cnt_q != '0);
    assign full       = (cnt_q == CNT_FULL);

endmodule

// File: rtl/sipo_word_collector.sv
// sipo_word_collector: shifts qualified serial bits into WIDTH-bit words
// (first bit lands in the LSB) and queues completed words in a 2-entry
// output FIFO drained by dout_valid/dout_ready.
// Build option: PARITY_CHECK_EN - each word is followed by an even-parity
// bit; parity_err pulses for one cycle when a pushed word fails. Without it
// parity_err is tied to 0.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   din          - serial data bit
//   din_valid    - din qualified this cycle
//   frame_sync   - discard partial word, restart bit count
//   dout         - head-of-queue word
//   dout_valid   - queue non-empty
//   dout_ready   - consumer accepts head this cycle
//   overflow     - sticky: a completed word was dropped (cleared by rst)
//   parity_err   - one-cycle pulse aligned with the word reaching the queue
module sipo_word_collector
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overflow,
    output logic             parity_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sipo_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] shifted;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic             q_full;
    logic             q_drop;

    always_comb begin
        shifted   = {din, shreg_q[WIDTH-1:1]};
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        state_d   = state_q;
        push      = 1'b0;
        push_data = shifted;
        if (frame_sync) begin
            // Resync: a bit arriving with frame_sync is bit 0 of the new word.
            state_d   = ST_COLLECT;
            bit_cnt_d = '0;
            if (din_valid) begin
                shreg_d   = shifted;
                bit_cnt_d = CNT_W'(1);
            end
        end else if (din_valid) begin
            case (state_q)
                ST_COLLECT: begin
                    shreg_d = shifted;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d = ST_PARITY;
`else
                        push = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: begin
                    // Parity bit is not shifted in; the word already sits in shreg.
`ifdef PARITY_CHECK_EN
                    push      = 1'b1;
                    push_data = shreg_q;
`endif
                    state_d = ST_COLLECT;
                end
            endcase
        end
    end

    assign pop = dout_valid & dout_ready;

    // drop only ever asserts while full; qualifying by full keeps intent explicit
    assign overflow_d = overflow_q | (q_drop & q_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_COLLECT;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef PARITY_CHECK_EN
    logic parity_err_q, parity_err_d;

    // Even parity: XOR of data bits and parity bit must be 0.
    assign parity_err_d = push & (^{shreg_q, din});

    always_ff @(posedge clk) begin
        if (rst) parity_err_q <= 1'b0;
        else     parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign overflow = overflow_q;

    sipo_out_queue #(.WIDTH(WIDTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (q_full),
        .drop       (q_drop)
    );

endmodule

// File: doc/sipo_word_collector.md
# sipo_word_collector

Serial-to-word receive stage that feeds the downstream datapath from a 1-bit serial stream. It shifts qualified bits into a WIDTH-bit register using the same bit order as the team's SIPO shift registers. Completed words go into a 2-entry output queue drained with a valid/ready handshake, with framing resync and sticky overflow reporting.

## Interface
- WIDTH, 4, data word width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high; clock clk
- din  input  1  serial data bit
- din_valid  input  1  din qualified this cycle
- frame_sync  input  1  discard partial word, restart bit count
- dout  output  WIDTH  head-of-queue word
- dout_valid  output  1  queue non-empty
- dout_ready  input  1  consumer accepts head this cycle
- overflow  output  1  sticky: a completed word was dropped
- parity_err  output  1  one-cycle pulse: pushed word failed parity; constant 0 without PARITY_CHECK_EN

## Operation
- Accepted bit: din_valid=1 at a rising edge.
- Shift rule on accepted data bit: shreg <= {din, shreg[WIDTH-1:1]}. New bit enters the MSB, so the first bit of a word ends in the LSB.
- bit_cnt: width $clog2(WIDTH+1); increments per accepted data bit.
- FSM states:
  - ST_COLLECT: on accepted bit with bit_cnt==WIDTH-1, the word {din, shreg[WIDTH-1:1]} is complete; bit_cnt returns to 0.
  - Without PARITY_CHECK_EN, the completed word is pushed on that same edge and the FSM stays in ST_COLLECT.
  - With PARITY_CHECK_EN, the FSM goes to ST_PARITY.
  - ST_PARITY: the next accepted bit is the parity bit. The word is pushed on that edge; parity_err is set if XOR(data bits, parity bit) != 0; the FSM returns to ST_COLLECT.
- Queue: 2 entries, FIFO order. Pop = dout_valid & dout_ready.
  - Push when full with no pop in the same cycle: the word is dropped and overflow is set to 1.
  - Push and pop in the same cycle while full: no drop.
  - Push into an empty queue: dout_valid rises next cycle.
- frame_sync=1: bit_cnt <= 0, FSM <= ST_COLLECT, partial word discarded.
  - If din_valid=1 in the same cycle, that bit is bit 0 of the new word.
  - Queue contents, overflow, and shreg contents are unaffected; stale shreg bits are shifted out.
- overflow clears only on rst.

## Timing
- Reset values:
  - dout=0, dout_valid=0, overflow=0, parity_err=0
  - shreg=0, bit_cnt=0, FSM=ST_COLLECT, queue empty
- rst has priority over every other input in the same cycle, including mid-word and mid-parity. All partial state is lost.
- Latency, last bit to output: dout_valid=1 and dout=word one cycle after the edge accepting the final bit (data bit, or parity bit when the parity check is enabled).
- parity_err is asserted in the same cycle that the word it describes first becomes visible at the tail. It is high for exactly 1 cycle.
- dout is registered. It is stable while dout_valid=1 and dout_ready=0. When the queue is empty, dout holds the last popped value.
- Throughput: one bit per cycle sustained. With dout_ready held at 1 there are no drops.
- din is ignored when din_valid=0; no state changes.

## Configuration
- PARITY_CHECK_EN:
  - Defined: each word is followed by one even-parity bit; adds ST_PARITY and the parity_err logic. Frame length is WIDTH+1 accepted bits.
  - Undefined: frame length is WIDTH bits, ST_PARITY is unreachable and not synthesized, and parity_err is tied to 0. Port list is unchanged.

## Structure
- Package sipo_pkg contains:
  - state enum (ST_COLLECT, ST_PARITY)
  - default WIDTH constant SIPO_WIDTH_DEFAULT=4
  - queue depth constant SIPO_QDEPTH=2
- Sub-module sipo_out_queue: 2-entry registered FIFO, parameterized by WIDTH. Ports: push, push_data, pop, dout, dout_valid, full, drop. overflow and parity_err alignment live in the top level.

## Test plan
All cases use WIDTH=4 and list bits first to last.
- Basic word: after rst, send bits 1,0,1,1 back-to-back with dout_ready=1. Expect dout=4'b1101 and dout_valid=1 for exactly 1 cycle, the cycle after the 4th bit.
- Overflow: hold dout_ready=0 and send three words, 4'h3, 4'h5, 4'h9.
  - After the third word, overflow=1.
  - Raise dout_ready: pops 4'h3 then 4'h5, then dout_valid=0. overflow stays 1 until rst.
- Full queue, simultaneous push and pop: complete a 3rd word in the same cycle as a pop. Expect overflow=0 and final order preserved.
- frame_sync resync: send 1,1, then frame_sync=1 together with bit 0, followed by 1,0,1. Expect a single word 4'b1010; the partial 1,1 never appears.
- Reset mid-word: send 3 bits, then rst for 1 cycle, then 0,0,1,0. Expect no output before the reset completes, then dout=4'b0100.
- PARITY_CHECK_EN, data 1,0,1,1:
  - Parity bit 1: dout=4'b1101, parity_err=0.
  - Parity bit 0: dout=4'b1101 with a 1-cycle parity_err=1 pulse.
